// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: ALU operation codes and
// the operand forwarding source select.
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/ex_operand_stage_hazard_detect.sv
// Combinational hazard unit: decode stall and E-stage operand forward selects.
// With EXSTAGE_FORWARD_EN undefined, M/E producers stall decode instead of forwarding.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int RADDR = 5
) (
    input  logic [RADDR-1:0] rs_d,
    input  logic [RADDR-1:0] rt_d,
    input  logic [RADDR-1:0] rs_e,
    input  logic [RADDR-1:0] rt_e,
    input  logic             memtoreg_e,
    input  logic             regwrite_e,
    input  logic [RADDR-1:0] writereg_e,
    input  logic             regwrite_m,
    input  logic [RADDR-1:0] writereg_m,
    input  logic             regwrite_w,
    input  logic [RADDR-1:0] writereg_w,
    output fwd_sel_t         fwd_a,
    output fwd_sel_t         fwd_b,
    output logic             stall_d
);

    function automatic fwd_sel_t pick_src(input logic [RADDR-1:0] src,
                                          input logic             wen_m,
                                          input logic [RADDR-1:0] dst_m,
                                          input logic             wen_w,
                                          input logic [RADDR-1:0] dst_w);
        if (wen_m && dst_m != '0 && dst_m == src)
            return FWD_M;
        else if (wen_w && dst_w != '0 && dst_w == src)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    logic load_use;

    always_comb begin
        fwd_a    = pick_src(rs_e, regwrite_m, writereg_m, regwrite_w, writereg_w);
        fwd_b    = pick_src(rt_e, regwrite_m, writereg_m, regwrite_w, writereg_w);
        load_use = memtoreg_e && (rt_e == rs_d || rt_e == rt_d) && rt_e != '0;
    end

`ifdef EXSTAGE_FORWARD_EN
    logic unused_e_dst;
    assign unused_e_dst = ^{regwrite_e, writereg_e};
    assign stall_d      = load_use;
`else
    // Without forwarding, any in-flight E or M producer of a decode source stalls.
    function automatic logic raw(input logic [RADDR-1:0] src);
        return src != '0 &&
               ((regwrite_e && writereg_e == src) ||
                (regwrite_m && writereg_m == src));
    endfunction

    assign stall_d = load_use || raw(rs_d) || raw(rt_d);
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// D->E pipeline register and execute operand selection; bubbles on stall/flush.
// Macro EXSTAGE_FORWARD_EN enables M/W result forwarding into the E operands.
module ex_operand_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_e,
    input  logic [WIDTH-1:0] rd1_d,
    input  logic [WIDTH-1:0] rd2_d,
    input  logic [WIDTH-1:0] signimm_d,
    input  logic [RADDR-1:0] rs_d,
    input  logic [RADDR-1:0] rt_d,
    input  logic [RADDR-1:0] rd_d,
    input  logic [2:0]       alucont_d,
    input  logic             alusrc_d,
    input  logic             regdst_d,
    input  logic             regwrite_d,
    input  logic             memtoreg_d,
    input  logic             memwrite_d,
    input  logic             regwrite_m,
    input  logic [RADDR-1:0] writereg_m,
    input  logic [WIDTH-1:0] aluout_m,
    input  logic             regwrite_w,
    input  logic [RADDR-1:0] writereg_w,
    input  logic [WIDTH-1:0] result_w,
    output logic [WIDTH-1:0] srca_e,
    output logic [WIDTH-1:0] srcb_e,
    output logic [2:0]       alucont_e,
    output logic [WIDTH-1:0] writedata_e,
    output logic [RADDR-1:0] writereg_e,
    output logic             regwrite_e,
    output logic             memtoreg_e,
    output logic             memwrite_e,
    output logic             stall_d
);

    logic [WIDTH-1:0] rd1_e, rd2_e, signimm_e;
    logic [RADDR-1:0] rs_e, rt_e, rd_e;
    logic             alusrc_e, regdst_e;
    fwd_sel_t         fwd_a, fwd_b;
    logic [WIDTH-1:0] opa, opb;

    hazard_detect #(.RADDR(RADDR)) u_hazard (
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .rs_e       (rs_e),
        .rt_e       (rt_e),
        .memtoreg_e (memtoreg_e),
        .regwrite_e (regwrite_e),
        .writereg_e (writereg_e),
        .regwrite_m (regwrite_m),
        .writereg_m (writereg_m),
        .regwrite_w (regwrite_w),
        .writereg_w (writereg_w),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall_d    (stall_d)
    );

    // E never holds: a stalled decode instruction is replaced by a bubble here.
    always_ff @(posedge clk) begin
        if (reset || flush_e || stall_d) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            signimm_e  <= '0;
            rs_e       <= '0;
            rt_e       <= '0;
            rd_e       <= '0;
            alucont_e  <= '0;
            alusrc_e   <= 1'b0;
            regdst_e   <= 1'b0;
            regwrite_e <= 1'b0;
            memtoreg_e <= 1'b0;
            memwrite_e <= 1'b0;
        end else begin
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            signimm_e  <= signimm_d;
            rs_e       <= rs_d;
            rt_e       <= rt_d;
            rd_e       <= rd_d;
            alucont_e  <= alucont_d;
            alusrc_e   <= alusrc_d;
            regdst_e   <= regdst_d;
            regwrite_e <= regwrite_d;
            memtoreg_e <= memtoreg_d;
            memwrite_e <= memwrite_d;
        end
    end

`ifdef EXSTAGE_FORWARD_EN
    always_comb begin
        unique case (fwd_a)
            FWD_M:   opa = aluout_m;
            FWD_W:   opa = result_w;
            default: opa = rd1_e;
        endcase
        unique case (fwd_b)
            FWD_M:   opb = aluout_m;
            FWD_W:   opb = result_w;
            default: opb = rd2_e;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{aluout_m, result_w, fwd_a, fwd_b};
    assign opa        = rd1_e;
    assign opb        = rd2_e;
`endif

    assign srca_e      = opa;
    assign writedata_e = opb;
    assign srcb_e      = alusrc_e ? signimm_e : opb;
    assign writereg_e  = regdst_e ? rd_e : rt_e;

endmodule
